// File: rtl/pipe_pkg.sv
// Shared types, constants and helpers for the 5-stage pipeline sequencer.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int REG_ZERO   = 0;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MDIV = 1'b1;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MDIV = 1'b1
  } state_e;

  function automatic int cnt_w(input int lat);
    return $clog2(lat);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              ld_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign ld_use  = ex_valid && ex_mem_read && (ex_rd != REG_AW'(REG_ZERO)) &&
                   (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: enables/flushes for PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MDIV_LAT = 4,
  parameter int REG_AW   = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mdiv_start,
  input  logic              ex_branch_taken,
  input  logic              mem_wait,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events,
`endif
  output logic              pc_en,
  output logic              if_en,
  output logic              id_en,
  output logic              ex_en,
  output logic              mem_en,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic              mdiv_done
);

  localparam int CW = cnt_w(MDIV_LAT);

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          ld_use;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .ld_use      (ld_use)
  );

  always_comb begin
    pc_en     = 1'b1;
    if_en     = 1'b1;
    id_en     = 1'b1;
    ex_en     = 1'b1;
    mem_en    = 1'b1;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    mdiv_done = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rst) begin
      {pc_en, if_en, id_en, ex_en, mem_en} = 5'b00000;
      {id_flush, ex_flush, mem_flush}      = 3'b111;
    end else if (state == ST_RUN) begin
      if (mem_wait) begin
        {pc_en, if_en, id_en, ex_en, mem_en} = 5'b00000;
      end else if (ex_valid && ex_branch_taken) begin
        id_flush = 1'b1;
        ex_flush = 1'b1;
      end else if (ex_valid && ex_mdiv_start) begin
        {pc_en, if_en, id_en, ex_en} = 4'b0000;
        mem_flush = 1'b1;
        state_nxt = ST_MDIV;
        cnt_nxt   = CW'(MDIV_LAT - 1);
      end else if (ld_use) begin
        pc_en    = 1'b0;
        if_en    = 1'b0;
        ex_flush = 1'b1;
      end
    end else begin
      // MUL/DIV holds EX; a memory wait freezes everything including the countdown.
      if (mem_wait) begin
        {pc_en, if_en, id_en, ex_en, mem_en} = 5'b00000;
      end else begin
        {pc_en, if_en, id_en, ex_en} = 4'b0000;
        if (cnt == CW'(1)) begin
          mdiv_done = 1'b1;
          ex_en     = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          mem_flush = 1'b1;
          cnt_nxt   = cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // id_flush outside reset is raised only by a taken-branch flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en)   stall_cycles <= stall_cycles + 32'd1;
      if (id_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencer for the 5-stage RISC-V core. Drives the enable and flush inputs of every enable-flop pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Resolves load-use stalls, taken-branch flushes, multi-cycle MUL/DIV occupancy and data-memory wait states. Sits beside the datapath and holds no data, only control.

Parameters:
MDIV_LAT, 4, cycles a MUL/DIV occupies EX; legal range 2..16.
REG_AW, 5, register-file address width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
id_rs1  in  REG_AW  source register 1 of the instruction in ID
id_rs2  in  REG_AW  source register 2 of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_rd  in  REG_AW  destination register of the EX instruction
ex_mem_read  in  1  EX instruction is a load
ex_mdiv_start  in  1  EX instruction is a MUL/DIV
ex_branch_taken  in  1  EX resolved a taken branch or jump
mem_wait  in  1  data memory not ready
pc_en  out  1  PC register enable
if_en  out  1  IF/ID enable
id_en  out  1  ID/EX enable
ex_en  out  1  EX/MEM enable
mem_en  out  1  MEM/WB enable
id_flush  out  1  load bubble into IF/ID
ex_flush  out  1  load bubble into ID/EX
mem_flush  out  1  load bubble into EX/MEM
mdiv_done  out  1  one-cycle pulse on the last MUL/DIV cycle

Behaviour:
- Reset is synchronous and active-high. While rst=1: all *_en=0, all *_flush=1, mdiv_done=0. On the first cycle after reset: state RUN, cnt=0.
- States: RUN, MDIV. Counter cnt has width clog2(MDIV_LAT).
- Outputs are combinational from state, cnt and inputs. State and cnt are registered.
- Default in RUN: all *_en=1, all *_flush=0.
- Priority in RUN, highest first:
  - mem_wait=1: all *_en=0, flushes=0, state and cnt hold.
  - ex_valid & ex_branch_taken: id_flush=1, ex_flush=1, all *_en=1. A coincident ex_mdiv_start is ignored.
  - ex_valid & ex_mdiv_start: next state MDIV, cnt<=MDIV_LAT-1. pc_en, if_en, id_en, ex_en=0. mem_flush=1, mem_en=1.
  - Load-use: ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). Response: pc_en=0, if_en=0, id_en=1, ex_flush=1. Exactly one bubble per hazard.
- In MDIV:
  - pc_en, if_en, id_en, ex_en=0. mem_flush=1, mem_en=1.
  - cnt decrements each cycle.
  - When cnt==1: mdiv_done=1, ex_en=1, mem_flush=0; next state RUN.
  - Total EX occupancy is MDIV_LAT cycles, counting the start cycle.
- mem_wait in MDIV: all *_en=0, mem_flush=0, cnt frozen, mdiv_done suppressed until the wait ends.
- Branch and load-use inputs are ignored in MDIV.
- Reset mid-MDIV: immediate return to RUN, cnt=0, no mdiv_done.
- Register x0 never causes a load-use stall.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments every cycle pc_en=0 and rst=0.
  - flush_events increments on every taken-branch flush.
  - Both wrap at 2^32 and clear on rst.
- Undefined: these ports and registers do not exist.

Decomposition:
- Package pipe_pkg holds:
  - state enum {RUN, MDIV}
  - REG_AW default
  - constant REG_ZERO = 0
  - function cnt_w(lat) returning clog2(lat)
- Sub-module hazard_detect: purely combinational load-use compare, output ld_use. Instantiated once.

Test Plan:
- Reset: rst=1 for 2 cycles -> all *_en=0 and all *_flush=1 during reset; first cycle after reset -> all *_en=1, flushes=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle with pc_en=0, if_en=0, ex_flush=1. Repeat with ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 together with a load-use match -> id_flush=1, ex_flush=1, pc_en=1, no stall.
- MUL/DIV: MDIV_LAT=4, ex_mdiv_start pulse -> pc_en=0 for 4 cycles, mdiv_done on the 4th cycle, RUN on the 5th.
- mem_wait=1 for 3 cycles during MDIV with cnt=2 -> all *_en=0, cnt holds at 2; completion delayed by 3 cycles.
- Reset mid-MDIV (cnt=2) -> RUN on the next cycle, mdiv_done never asserts. With PIPE_PERF_CNT_EN defined -> stall_cycles equals the count of pc_en=0 cycles.
